zjh_cmp_sched: RTL



---
 rtl/zjh_cmp_pkg.sv | 23 ++
 rtl/zjh_rr_arb.sv | 41 ++++
 rtl/zjh_cmp_sched.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/zjh_cmp_pkg.sv
// Shared types and helpers for the round-robin comparator scheduler.
package zjh_cmp_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zjh_rr_arb.sv
// Combinational round-robin pick: first set request after ptr_i, with wrap.
module zjh_rr_arb
    import zjh_cmp_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]        req_i,
    input  logic [idx_w(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]        gnt_c,
    output logic [idx_w(NREQ)-1:0] idx_c,
    output logic                   any_c
);

    localparam int unsigned IW = idx_w(NREQ);

    logic [IW-1:0] k_idx;

    // Scan from the farthest slot back toward ptr+1 so the nearest hit is the final winner.
    always_comb begin
        int k;
        k     = 0;
        k_idx = '0;
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int off = int'(NREQ); off >= 1; off--) begin
            k = int'(ptr_i) + off;
            if (k >= int'(NREQ)) begin
                k = k - int'(NREQ);
            end
            k_idx = IW'(k);
            if (req_i[k_idx]) begin
                gnt_c        = '0;
                gnt_c[k_idx] = 1'b1;
                idx_c        = k_idx;
                any_c        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zjh_cmp_sched.sv
// Round-robin scheduler sharing one external magnitude comparator among NREQ requesters.
// Optional flag-consistency check (sticky Err) is built only when ZJH_CMP_CHECK_EN is defined.
module zjh_cmp_sched
    import zjh_cmp_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   Clock,
    input  logic                   Sclr,
    input  logic [NREQ-1:0]        Req,
    input  logic [NREQ*WIDTH-1:0]  ReqA,
    input  logic [NREQ*WIDTH-1:0]  ReqB,
    output logic [NREQ-1:0]        Gnt,
    output logic [WIDTH-1:0]       CmpA,
    output logic [WIDTH-1:0]       CmpB,
    input  logic                   AEB,
    input  logic                   AGB,
    input  logic                   ALB,
    output logic                   Done,
    output logic [idx_w(NREQ)-1:0] DoneId,
    output logic                   ResEQ,
    output logic                   ResGT,
    output logic                   ResLT,
    output logic                   Busy,
    output logic                   Err
);

    localparam int unsigned IW = idx_w(NREQ);

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    tag_q, tag_d;
    logic [IW-1:0]    doneid_q, doneid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cmpa_q, cmpa_d;
    logic [WIDTH-1:0] cmpb_q, cmpb_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    cmp_res_t         res_q, res_d;
    cmp_res_t         flags_c;

    logic [WIDTH-1:0] opa_c [NREQ];
    logic [WIDTH-1:0] opb_c [NREQ];

    logic [NREQ-1:0]  arb_gnt_c;
    logic [IW-1:0]    arb_idx_c;
    logic             arb_any_c;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign opa_c[g] = ReqA[g*WIDTH +: WIDTH];
        assign opb_c[g] = ReqB[g*WIDTH +: WIDTH];
    end

    assign flags_c = {AEB, AGB, ALB};

    zjh_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i (Req),
        .ptr_i (ptr_q),
        .gnt_c (arb_gnt_c),
        .idx_c (arb_idx_c),
        .any_c (arb_any_c)
    );

    // Next-state and combinational grant.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        cmpa_d   = cmpa_q;
        cmpb_d   = cmpb_q;
        doneid_d = doneid_q;
        res_d    = res_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        Gnt      = '0;
        case (state_q)
            ST_IDLE: begin
                Gnt = arb_gnt_c;
                if (arb_any_c) begin
                    cmpa_d  = opa_c[arb_idx_c];
                    cmpb_d  = opb_c[arb_idx_c];
                    ptr_d   = arb_idx_c;
                    tag_d   = arb_idx_c;
                    cnt_d   = CNT_W'(SETTLE);
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d  = cnt_q - CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    res_d    = flags_c;
                    doneid_d = tag_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (Sclr) begin
            Gnt = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Sclr) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IW'(NREQ - 1);
            tag_q    <= '0;
            cnt_q    <= '0;
            cmpa_q   <= '0;
            cmpb_q   <= '0;
            doneid_q <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            cmpa_q   <= cmpa_d;
            cmpb_q   <= cmpb_d;
            doneid_q <= doneid_d;
            res_q    <= res_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

`ifdef ZJH_CMP_CHECK_EN
    logic sample_c;
    logic err_q;

    assign sample_c = (state_q == ST_SETTLE) && (cnt_q == CNT_W'(1));

    // Flags must be exactly one-hot whenever they are sampled.
    always_ff @(posedge Clock) begin
        if (Sclr) begin
            err_q <= 1'b0;
        end else if (sample_c && !$onehot({AEB, AGB, ALB})) begin
            err_q <= 1'b1;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign CmpA   = cmpa_q;
    assign CmpB   = cmpb_q;
    assign Done   = done_q;
    assign DoneId = doneid_q;
    assign ResEQ  = res_q.eq;
    assign ResGT  = res_q.gt;
    assign ResLT  = res_q.lt;
    assign Busy   = busy_q;

endmodule
